// File: rtl/timer_service_master_pkg.sv
// timer_service_master_pkg
//   Shared definitions for the interval-timer service master: timer register
//   addresses, control-register bit positions, the sequencer state enum, the
//   bus-engine phase enum and a helper that builds control-register words.
package timer_service_master_pkg;

    // Timer slave register map
    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    // Control register bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // Sequencer states
    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTL,
        S_RUN,
        S_ACK,
        S_STOP_W,
        S_STOP_CLR,
        S_SNAP_W,
        S_RD_L,
        S_RD_H
    } tsm_state_e;

    // Bus engine phases: what the bus is doing in the current cycle
    typedef enum logic [1:0] {
        P_IDLE,
        P_WRITE,
        P_RD_A,
        P_RD_B
    } bus_phase_e;

    function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                              input logic start, input logic stop);
        logic [15:0] w;
        w             = '0;
        w[CTRL_ITO]   = ito;
        w[CTRL_CONT]  = cont;
        w[CTRL_START] = start;
        w[CTRL_STOP]  = stop;
        return w;
    endfunction

endpackage

// File: rtl/timer_service_master_if.sv
// timer_service_master_if
//   Avalon-MM link between the service master and the timer s1 slave port,
//   plus the timer interrupt line.
//   av_address    : register address (master -> slave)
//   av_chipselect : slave select (master -> slave)
//   av_write_n    : active-low write strobe (master -> slave)
//   av_writedata  : write data (master -> slave)
//   av_readdata   : registered read data, valid one cycle after the address
//   timer_irq     : level interrupt from the timer (slave -> master)
interface timer_service_master_if;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        timer_irq;

    modport master (
        output av_address,
        output av_chipselect,
        output av_write_n,
        output av_writedata,
        input  av_readdata,
        input  timer_irq
    );

    modport slave (
        input  av_address,
        input  av_chipselect,
        input  av_write_n,
        input  av_writedata,
        output av_readdata,
        output timer_irq
    );
endinterface

// File: rtl/timer_service_master_avmm_single_master.sv
// avmm_single_master
//   Single-transaction Avalon-MM engine with registered bus outputs.
//   A write occupies one bus cycle; a read occupies two (A: address out,
//   B: address held, read data sampled at the end of B).
//   Ports:
//     clk, reset_n  : clock, asynchronous active-low reset
//     cmd_valid     : request a transaction this cycle
//     cmd_write     : 1 = write, 0 = read
//     cmd_addr      : register address
//     cmd_wdata     : write data
//     done          : high during read cycle B; rdata is valid in that cycle
//     rdata         : read data (straight from the slave)
//     dbg_phase     : current bus phase
//     av            : master side of the timer bus
//
//   Handshake: a command is taken on any clock edge where cmd_valid is high
//   and the engine is not in read cycle A (cycle A must be followed by B).
//   A taken command appears on the bus in the next cycle, so back-to-back
//   writes and read-after-read on consecutive cycles need no idle gap.
module avmm_single_master
    import timer_service_master_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        done,
    output logic [15:0] rdata,
    output bus_phase_e  dbg_phase,
    timer_service_master_if.master av
);

    bus_phase_e  phase_q, phase_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= P_IDLE;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            phase_q <= phase_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cs_d    = cs_q;
        wn_d    = wn_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (phase_q)
            // Cycle A always continues into B with address held
            P_RD_A: phase_d = P_RD_B;
            default: begin
                if (cmd_valid) begin
                    cs_d    = 1'b1;
                    wn_d    = ~cmd_write;
                    addr_d  = cmd_addr;
                    data_d  = cmd_write ? cmd_wdata : 16'h0000;
                    phase_d = cmd_write ? P_WRITE : P_RD_A;
                end else begin
                    // Address and data are left as they were; only the
                    // strobes return to idle.
                    cs_d    = 1'b0;
                    wn_d    = 1'b1;
                    phase_d = P_IDLE;
                end
            end
        endcase
    end

    assign av.av_chipselect = cs_q;
    assign av.av_write_n    = wn_q;
    assign av.av_address    = addr_q;
    assign av.av_writedata  = data_q;

    assign done      = (phase_q == P_RD_B);
    assign rdata     = av.av_readdata;
    assign dbg_phase = phase_q;

endmodule

// File: rtl/timer_service_master.sv
// timer_service_master
//   Avalon-MM initiator that programs, starts, stops and services the 16-bit
//   interval timer on behalf of fabric logic, counts serviced ticks and reads
//   back counter snapshots.
//   Parameters:
//     CONTINUOUS : value written to control CONT on start
//     TICK_CNT_W : width of tick_count, 1..32
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     cfg_period   : load value, sampled on an accepted cfg_start
//     cfg_start    : request to program and start (IDLE only)
//     cfg_stop     : request to stop (RUN; latched if it arrives while busy)
//     snap_req     : request a counter snapshot (RUN only)
//     busy         : sequencer is neither IDLE nor RUN
//     running      : timer started and not yet stopped
//     tick         : one-cycle pulse per serviced irq
//     tick_count   : serviced ticks, wrapping
//     snap_value   : last snapshot {hi,lo}
//     snap_valid   : one-cycle pulse when snap_value updates
//     cfg_err      : one-cycle pulse when cfg_start carries a zero period
//     dbg_state    : sequencer state
//     dbg_phase    : bus engine phase
//     av           : master side of the timer bus
module timer_service_master
    import timer_service_master_pkg::*;
#(
    parameter bit CONTINUOUS = 1'b1,
    parameter int TICK_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           cfg_period,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic                  snap_req,
    output logic                  busy,
    output logic                  running,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [31:0]           snap_value,
    output logic                  snap_valid,
    output logic                  cfg_err,
    output tsm_state_e            dbg_state,
    output bus_phase_e            dbg_phase,
    timer_service_master_if.master av
);

    tsm_state_e            state_q, state_d;
    logic [31:0]           period_q;
    logic                  running_q;
    logic [TICK_CNT_W-1:0] tick_count_q;
    logic [31:0]           snap_value_q;
    logic [15:0]           snap_lo_q;
    logic                  snap_valid_q;
    logic                  cfg_err_q;
    logic                  stop_pend_q;
    logic                  irq_hold_q;

    logic                  cmd_valid;
    logic                  cmd_write;
    logic [2:0]            cmd_addr;
    logic [15:0]           cmd_wdata;
    logic                  rd_done;
    logic [15:0]           rdata;

    logic                  accept_start;
    logic                  reject_start;

    avmm_single_master u_bus (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .done      (rd_done),
        .rdata     (rdata),
        .dbg_phase (dbg_phase),
        .av        (av)
    );

    assign accept_start = (state_q == S_IDLE) && cfg_start && (cfg_period != '0);
    assign reject_start = (state_q == S_IDLE) && cfg_start && (cfg_period == '0);
    assign busy         = (state_q != S_IDLE) && (state_q != S_RUN);

    always_comb begin
        state_d   = state_q;
        cmd_valid = 1'b0;
        cmd_write = 1'b1;
        cmd_addr  = REG_STATUS;
        cmd_wdata = 16'h0000;
        case (state_q)
            S_IDLE: begin
                if (accept_start) state_d = S_WR_PL;
            end
            S_WR_PL: begin
                cmd_valid = 1'b1;
                cmd_addr  = REG_PERIODL;
                cmd_wdata = period_q[15:0];
                state_d   = S_WR_PH;
            end
            S_WR_PH: begin
                cmd_valid = 1'b1;
                cmd_addr  = REG_PERIODH;
                cmd_wdata = period_q[31:16];
                state_d   = S_WR_CTL;
            end
            // Period writes stop the timer, so START goes out last
            S_WR_CTL: begin
                cmd_valid = 1'b1;
                cmd_addr  = REG_CONTROL;
                cmd_wdata = ctrl_word(1'b1, CONTINUOUS, 1'b1, 1'b0);
                state_d   = S_RUN;
            end
            S_RUN: begin
                // irq is still high in the first RUN cycle after ACK because
                // the slave drops it one cycle after the status write.
                if (cfg_stop || stop_pend_q)      state_d = S_STOP_W;
                else if (av.timer_irq && !irq_hold_q) state_d = S_ACK;
                else if (snap_req)                state_d = S_SNAP_W;
            end
            S_ACK: begin
                cmd_valid = 1'b1;
                cmd_addr  = REG_STATUS;
                state_d   = CONTINUOUS ? S_RUN : S_IDLE;
            end
            S_STOP_W: begin
                cmd_valid = 1'b1;
                cmd_addr  = REG_CONTROL;
                cmd_wdata = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
                state_d   = S_STOP_CLR;
            end
            // Clears a timeout that fired before the stop took effect
            S_STOP_CLR: begin
                cmd_valid = 1'b1;
                cmd_addr  = REG_STATUS;
                state_d   = S_IDLE;
            end
            S_SNAP_W: begin
                cmd_valid = 1'b1;
                cmd_addr  = REG_SNAPL;
                state_d   = S_RD_L;
            end
            // The read of snap_l is offered until the engine takes it; the
            // snap_h read is issued in the sample cycle of snap_l so the two
            // reads run back to back.
            S_RD_L: begin
                cmd_valid = 1'b1;
                cmd_write = 1'b0;
                cmd_addr  = rd_done ? REG_SNAPH : REG_SNAPL;
                if (rd_done) state_d = S_RD_H;
            end
            S_RD_H: begin
                if (rd_done) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            period_q     <= '0;
            running_q    <= 1'b0;
            tick_count_q <= '0;
            snap_value_q <= '0;
            snap_lo_q    <= '0;
            snap_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            stop_pend_q  <= 1'b0;
            irq_hold_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= reject_start;
            if (accept_start) period_q <= cfg_period;

            if (state_q == S_WR_CTL)
                running_q <= 1'b1;
            else if ((state_q == S_STOP_W) || ((state_q == S_ACK) && !CONTINUOUS))
                running_q <= 1'b0;

            if (state_q == S_ACK) tick_count_q <= tick_count_q + TICK_CNT_W'(1);
            irq_hold_q <= (state_q == S_ACK);

            // A stop seen while busy waits for RUN; it is consumed there, and
            // is meaningless once the sequence lands back in IDLE.
            if ((state_q == S_RUN) || (state_d == S_IDLE))
                stop_pend_q <= 1'b0;
            else if (busy && cfg_stop)
                stop_pend_q <= 1'b1;

            if ((state_q == S_RD_L) && rd_done) snap_lo_q <= rdata;
            if ((state_q == S_RD_H) && rd_done) snap_value_q <= {rdata, snap_lo_q};
            snap_valid_q <= (state_q == S_RD_H) && rd_done;
        end
    end

    assign running    = running_q;
    assign tick       = (state_q == S_ACK);
    assign tick_count = tick_count_q;
    assign snap_value = snap_value_q;
    assign snap_valid = snap_valid_q;
    assign cfg_err    = cfg_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_timer_service_master.sv
// tb_timer_service_master
//   Bench for timer_service_master with a behavioural timer slave. Bus events
//   are predicted into exp_q by the stimulus tasks and checked in order by a
//   bus monitor.
module tb_timer_service_master;
    import timer_service_master_pkg::*;

    localparam int TCW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]    cfg_period = '0;
    logic           cfg_start = 1'b0;
    logic           cfg_stop = 1'b0;
    logic           snap_req = 1'b0;
    logic           busy, running, tick, snap_valid, cfg_err;
    logic [TCW-1:0] tick_count;
    logic [31:0]    snap_value;
    tsm_state_e     dbg_state;
    bus_phase_e     dbg_phase;

    timer_service_master_if av_if ();

    timer_service_master #(.CONTINUOUS(1'b1), .TICK_CNT_W(TCW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_period (cfg_period),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .snap_req   (snap_req),
        .busy       (busy),
        .running    (running),
        .tick       (tick),
        .tick_count (tick_count),
        .snap_value (snap_value),
        .snap_valid (snap_valid),
        .cfg_err    (cfg_err),
        .dbg_state  (dbg_state),
        .dbg_phase  (dbg_phase),
        .av         (av_if)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] exp_q[$];      // {is_read, addr, wdata}
    int          cyc = 0;
    int          ev_count = 0;
    int          cyc_log[64];
    int          tick_seen = 0;
    int          snap_seen = 0;
    int          err_seen = 0;
    logic        rd_b = 1'b0;
    int          exp_ticks = 0;

    // ---------------- timer slave model ----------------
    logic        irq_fire = 1'b0;
    logic [31:0] slave_cnt = 32'h0005_1234;
    logic [15:0] slave_snap_l, slave_snap_h;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            av_if.timer_irq   <= 1'b0;
            av_if.av_readdata <= '0;
            slave_snap_l      <= '0;
            slave_snap_h      <= '0;
        end else begin
            if (av_if.av_chipselect && !av_if.av_write_n && av_if.av_address == 3'd0)
                av_if.timer_irq <= 1'b0;
            else if (irq_fire)
                av_if.timer_irq <= 1'b1;
            if (av_if.av_chipselect && !av_if.av_write_n && av_if.av_address == 3'd4) begin
                slave_snap_l <= slave_cnt[15:0];
                slave_snap_h <= slave_cnt[31:16];
            end
            case (av_if.av_address)
                3'd4:    av_if.av_readdata <= slave_snap_l;
                3'd5:    av_if.av_readdata <= slave_snap_h;
                default: av_if.av_readdata <= 16'h0000;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%h expected=0x%h", tag, act, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    always @(negedge clk) begin : mon
        logic [19:0] ev;
        logic [19:0] e;
        logic        have;
        have = 1'b0;
        ev   = '0;
        if (av_if.av_chipselect && !av_if.av_write_n) begin
            ev   = {1'b0, av_if.av_address, av_if.av_writedata};
            have = 1'b1;
        end else if (av_if.av_chipselect && av_if.av_write_n && !rd_b) begin
            ev   = {1'b1, av_if.av_address, 16'h0000};
            have = 1'b1;
        end
        rd_b <= av_if.av_chipselect && av_if.av_write_n && !rd_b;
        if (tick)       tick_seen <= tick_seen + 1;
        if (snap_valid) snap_seen <= snap_seen + 1;
        if (cfg_err)    err_seen  <= err_seen + 1;
        if (have) begin
            cyc_log[ev_count % 64] <= cyc;
            ev_count <= ev_count + 1;
            if (exp_q.size() == 0) begin
                check("bus_extra_depth", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("bus_event", ev, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_w(input logic [2:0] a, input logic [15:0] d);
        exp_q.push_back({1'b0, a, d});
    endtask

    task automatic push_r(input logic [2:0] a);
        exp_q.push_back({1'b1, a, 16'h0000});
    endtask

    task automatic pulse_start(input logic [31:0] p);
        cfg_period = p;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    task automatic pulse_stop();
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
    endtask

    task automatic pulse_snap();
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    task automatic start_timer(input logic [31:0] p);
        push_w(3'd2, p[15:0]);
        push_w(3'd3, p[31:16]);
        push_w(3'd1, 16'h0007);
        pulse_start(p);
        for (int i = 0; i < 10; i++) begin
            if (running) break;
            @(negedge clk);
        end
        cycles(3);
    endtask

    task automatic service_irq();
        int target;
        target = tick_seen + 1;
        push_w(3'd0, 16'h0000);
        irq_fire = 1'b1;
        @(negedge clk);
        irq_fire = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tick_seen >= target) break;
            @(negedge clk);
        end
        exp_ticks++;
        cycles(4);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cs"},    av_if.av_chipselect, 1'b0);
        check({tag, "_wn"},    av_if.av_write_n, 1'b1);
        check({tag, "_addr"},  av_if.av_address, 3'd0);
        check({tag, "_wdata"}, av_if.av_writedata, 16'h0000);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_run"},   running, 1'b0);
        check({tag, "_tick"},  tick, 1'b0);
        check({tag, "_tcnt"},  tick_count, '0);
        check({tag, "_snapv"}, snap_value, 32'h0);
        check({tag, "_snapp"}, snap_valid, 1'b0);
        check({tag, "_err"},   cfg_err, 1'b0);
        check({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          n0;
        int          s0;
        int          t0;
        logic [15:0] rnd_lo, rnd_hi;

        cycles(3);
        check_reset_vals("rst");
        reset_n = 1'b1;
        cycles(2);

        // program and start: three consecutive writes
        start_timer(32'h0001_86A0);
        check("start_running", running, 1'b1);
        check("start_busy", busy, 1'b0);
        check("start_state", dbg_state, S_RUN);
        check("start_consecutive", cyc_log[(ev_count - 1) % 64] - cyc_log[(ev_count - 3) % 64], 2);

        // three irqs, one service each
        t0 = tick_seen;
        for (int i = 0; i < 3; i++) service_irq();
        check("irq_ticks", tick_seen - t0, 3);
        check("irq_tick_count", tick_count, exp_ticks % (1 << TCW));

        // snapshot
        slave_cnt = 32'h0005_1234;
        s0 = snap_seen;
        push_w(3'd4, 16'h0000);
        push_r(3'd4);
        push_r(3'd5);
        pulse_snap();
        for (int i = 0; i < 20; i++) begin
            if (snap_valid) break;
            @(negedge clk);
        end
        check("snap_value", snap_value, 32'h0005_1234);
        cycles(3);
        check("snap_pulses", snap_seen - s0, 1);
        check("snap_contiguous", cyc_log[(ev_count - 1) % 64] - cyc_log[(ev_count - 3) % 64], 3);

        // cfg_start while running is dropped (no bus events predicted)
        pulse_start(32'h0000_0005);
        cycles(4);
        check("start_in_run_state", dbg_state, S_RUN);

        // stop from RUN
        push_w(3'd1, 16'h0008);
        push_w(3'd0, 16'h0000);
        pulse_stop();
        cycles(4);
        check("stop_running", running, 1'b0);
        check("stop_state", dbg_state, S_IDLE);

        // zero period rejected
        n0 = ev_count;
        pulse_start(32'h0);
        cycles(4);
        check("zero_err_pulses", err_seen, 1);
        check("zero_no_bus", ev_count - n0, 0);
        check("zero_running", running, 1'b0);
        check("zero_state", dbg_state, S_IDLE);

        // stop arriving during WR_PH is held until RUN
        push_w(3'd2, 16'h0010);
        push_w(3'd3, 16'h0000);
        push_w(3'd1, 16'h0007);
        push_w(3'd1, 16'h0008);
        push_w(3'd0, 16'h0000);
        pulse_start(32'h0000_0010);
        @(negedge clk);
        pulse_stop();
        for (int i = 0; i < 20; i++) begin
            if (dbg_state == S_IDLE) break;
            @(negedge clk);
        end
        cycles(2);
        check("pend_stop_running", running, 1'b0);
        check("pend_stop_state", dbg_state, S_IDLE);
        check("pend_stop_drained", exp_q.size(), 0);

        // restart with a random period; irq and snap_req together: irq wins
        rnd_lo = 16'($urandom_range(1, 16'hFFFF));
        rnd_hi = 16'($urandom_range(0, 16'hFFFF));
        start_timer({rnd_hi, rnd_lo});
        check("restart_running", running, 1'b1);
        s0 = snap_seen;
        t0 = tick_seen;
        push_w(3'd0, 16'h0000);
        irq_fire = 1'b1;
        @(negedge clk);
        irq_fire = 1'b0;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        cycles(10);
        exp_ticks++;
        check("race_tick", tick_seen - t0, 1);
        check("race_snap_dropped", snap_seen - s0, 0);
        check("race_tick_count", tick_count, exp_ticks % (1 << TCW));

        // reset in the middle of a snapshot
        push_w(3'd4, 16'h0000);
        push_r(3'd4);
        pulse_snap();
        cycles(2);
        #2 reset_n = 1'b0;
        cycles(3);
        check_reset_vals("midrst");
        check("midrst_drained", exp_q.size(), 0);
        reset_n = 1'b1;
        exp_ticks = 0;
        cycles(2);

        // tick_count wrap: 17 services with a 4-bit counter
        start_timer(32'h0000_0100);
        t0 = tick_seen;
        for (int i = 0; i < 17; i++) service_irq();
        check("wrap_ticks", tick_seen - t0, 17);
        check("wrap_tick_count", tick_count, exp_ticks % (1 << TCW));
        check("wrap_one", tick_count, 1);

        cycles(5);
        check("bus_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
